// File: rtl/mono_video_stage.sv
// mono_video_stage: two-stage RGB222 -> RGB888 pixel stage with mono tint, frame-locked palette and vsync watchdog
module mono_video_stage #(
   parameter int unsigned MAX_FRAME_CLKS = 2_000_000
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ce_pix,
   input  logic [1:0] r_in,
   input  logic [1:0] g_in,
   input  logic [1:0] b_in,
   input  logic       hs_in,
   input  logic       vs_in,
   input  logic       hblank_in,
   input  logic       vblank_in,
   input  logic [1:0] disp_color,
   input  logic       mono_en,
   output logic [7:0] r_out,
   output logic [7:0] g_out,
   output logic [7:0] b_out,
   output logic       hs_out,
   output logic       vs_out,
   output logic       hblank_out,
   output logic       vblank_out,
   output logic       ce_pix_out,
   output logic       sync_lost
);
   localparam int CW = $clog2(MAX_FRAME_CLKS + 1);
   localparam logic [CW-1:0] CMAX = CW'(MAX_FRAME_CLKS);

   logic [1:0] r1_q, g1_q, b1_q, lum1_q, lum_d, rg_max;
   logic blank1_q, hs1_q, vs1_q, hb1_q, vb1_q;
   logic [7:0] r2_q, g2_q, b2_q, r2_d, g2_d, b2_d, cr, cg, cb;
   logic hs2_q, vs2_q, hb2_q, vb2_q, ce_q;
   logic vbp_q, vsp_q, vb_rise, kill;
   logic [1:0] pal_q, pal_d;
   logic mono_q, mono_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // lum 0..3 scales C by 0, 1/3, 2/3, 1; the +FF bias makes lum 3 return C exactly
   function automatic logic [7:0] tint(input logic [7:0] c, input logic [1:0] l);
      logic [15:0] p;
      p = 16'(c) * 16'({4{l}}) + 16'd255;
      return p[15:8];
   endfunction

   always_comb begin
      rg_max = (r_in > g_in) ? r_in : g_in;
      lum_d = (rg_max > b_in) ? rg_max : b_in;
      vb_rise = ce_pix & vblank_in & ~vbp_q;
      pal_d = (reset | vb_rise) ? disp_color : pal_q;
      mono_d = (reset | vb_rise) ? mono_en : mono_q;
      cr = (pal_d == 2'd1) ? 8'h33 : 8'hFF;
      cg = (pal_d == 2'd2) ? 8'hB0 : 8'hFF;
      cb = (pal_d == 2'd1) ? 8'h33 : (pal_d == 2'd2) ? 8'h00 : 8'hFF;
      kill = blank1_q | sync_lost;
      r2_d = kill ? 8'h00 : mono_d ? tint(cr, lum1_q) : {4{r1_q}};
      g2_d = kill ? 8'h00 : mono_d ? tint(cg, lum1_q) : {4{g1_q}};
      b2_d = kill ? 8'h00 : mono_d ? tint(cb, lum1_q) : {4{b1_q}};
      cnt_d = (vs_in & ~vsp_q) ? '0 : (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_sys) begin
      pal_q <= pal_d;
      mono_q <= mono_d;
      if (reset) begin
         {r1_q, g1_q, b1_q, lum1_q} <= '0;
         {blank1_q, hs1_q, vs1_q, hb1_q, vb1_q} <= '0;
         {r2_q, g2_q, b2_q} <= '0;
         {hs2_q, vs2_q, hb2_q, vb2_q} <= '0;
         ce_q <= 1'b0;
         vbp_q <= 1'b0;
         vsp_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         ce_q <= ce_pix;
         vsp_q <= vs_in;
         cnt_q <= cnt_d;
         if (ce_pix) begin
            r1_q <= r_in;
            g1_q <= g_in;
            b1_q <= b_in;
            lum1_q <= lum_d;
            blank1_q <= hblank_in | vblank_in;
            hs1_q <= hs_in;
            vs1_q <= vs_in;
            hb1_q <= hblank_in;
            vb1_q <= vblank_in;
            r2_q <= r2_d;
            g2_q <= g2_d;
            b2_q <= b2_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            hb2_q <= hb1_q;
            vb2_q <= vb1_q;
            vbp_q <= vblank_in;
         end
      end
   end

   assign r_out = r2_q;
   assign g_out = g2_q;
   assign b_out = b2_q;
   assign hs_out = hs2_q;
   assign vs_out = vs2_q;
   assign hblank_out = hb2_q;
   assign vblank_out = vb2_q;
   assign ce_pix_out = ce_q;
   assign sync_lost = (cnt_q == CMAX);
endmodule
